// File: rtl/lvds_frame_aligner.sv
// Frame aligner behind the LVDS receiver: hunts for the sync word at either bit phase,
// then slices the 2-bit stream into 16-bit words grouped in fixed-length frames.
//
// state  | meaning
// HUNT   | searching both bit phases for SYNC_WORD, no words emitted
// LOCKED | slicing words every 8 cycles, checking sync at each frame start
module lvds_frame_aligner #(
    parameter logic [15:0] SYNC_WORD   = 16'hA5C3,
    parameter int unsigned FRAME_WORDS = 4,
    parameter int unsigned MISS_LIMIT  = 2
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic [1:0]  rx_data,
    input  logic        clear_err,
    output logic [15:0] word_data,
    output logic        word_valid,
    output logic        frame_start,
    output logic        locked,
    output logic        phase,
    output logic [7:0]  sync_err_count
);

    typedef enum logic {HUNT, LOCKED} state_t;

    localparam logic [7:0] LAST_WI  = 8'(FRAME_WORDS);
    localparam logic [3:0] MISS_LIM = 4'(MISS_LIMIT);

    state_t      state, state_nxt;
    // Both windows only reach back 17 bits including the current pair, so 15 stored bits suffice.
    logic [14:0] sr;
    logic [16:0] sr_nxt;
    logic [15:0] win_even, win_odd, win_sel;
    logic [2:0]  pc, pc_nxt;
    logic [7:0]  wi, wi_nxt, slot;
    logic [3:0]  miss_cnt, miss_nxt, miss_inc;
    logic        phase_nxt, word_valid_nxt, frame_start_nxt;
    logic [15:0] word_data_nxt;
    logic [7:0]  err_nxt;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state          <= HUNT;
            sr             <= '0;
            pc             <= '0;
            wi             <= '0;
            miss_cnt       <= '0;
            phase          <= 1'b0;
            word_valid     <= 1'b0;
            frame_start    <= 1'b0;
            word_data      <= '0;
            sync_err_count <= '0;
        end else begin
            state          <= state_nxt;
            sr             <= sr_nxt[14:0];
            pc             <= pc_nxt;
            wi             <= wi_nxt;
            miss_cnt       <= miss_nxt;
            phase          <= phase_nxt;
            word_valid     <= word_valid_nxt;
            frame_start    <= frame_start_nxt;
            word_data      <= word_data_nxt;
            sync_err_count <= err_nxt;
        end
    end

    assign locked = (state == LOCKED);

    always_comb begin
        sr_nxt          = {sr, rx_data};
        win_even        = sr_nxt[15:0];
        win_odd         = sr_nxt[16:1];
        win_sel         = phase ? win_odd : win_even;
        // wi holds the slot completed last; slot is the one completing now.
        slot            = (wi == LAST_WI) ? 8'd0 : wi + 8'd1;
        miss_inc        = miss_cnt + 4'd1;

        state_nxt       = state;
        pc_nxt          = pc;
        wi_nxt          = wi;
        miss_nxt        = miss_cnt;
        phase_nxt       = phase;
        word_valid_nxt  = 1'b0;
        frame_start_nxt = 1'b0;
        word_data_nxt   = word_data;
        err_nxt         = sync_err_count;

        case (state)
            HUNT: begin
                if (win_even == SYNC_WORD || win_odd == SYNC_WORD) begin
                    phase_nxt = (win_even != SYNC_WORD);
                    pc_nxt    = '0;
                    wi_nxt    = '0;
                    miss_nxt  = '0;
                    state_nxt = LOCKED;
                end
            end
            LOCKED: begin
                pc_nxt = pc + 3'd1;
                if (pc == 3'd7) begin
                    wi_nxt = slot;
                    if (slot == 8'd0) begin
                        if (win_sel == SYNC_WORD) begin
                            miss_nxt = '0;
                        end else begin
                            miss_nxt = miss_inc;
                            if (sync_err_count != 8'hFF) err_nxt = sync_err_count + 8'd1;
                            if (miss_inc == MISS_LIM) state_nxt = HUNT;
                        end
                    end else begin
                        word_valid_nxt  = 1'b1;
                        frame_start_nxt = (slot == 8'd1);
                        word_data_nxt   = win_sel;
                    end
                end
            end
            default: state_nxt = HUNT;
        endcase

        if (clear_err) err_nxt = '0;
    end

endmodule

// File: doc/lvds_frame_aligner.md
# lvds_frame_aligner

Downstream companion of the LVDS receiver: consumes the 2-bit-per-clock `rx_out` stream, hunts for a 16-bit sync word at either bit phase, and, once locked, slices the stream into 16-bit data words grouped in fixed-length frames. Each frame is one sync word followed by `FRAME_WORDS` data words. The block tracks sync integrity, drops lock after repeated sync misses, and exports a saturating error counter for CSR readback.

## Interface
Parameters:
- `SYNC_WORD`, 16'hA5C3, sync pattern, MSB first.
- `FRAME_WORDS`, 4, data words per frame, legal 1..255.
- `MISS_LIMIT`, 2, consecutive sync mismatches that force return to hunt, legal 1..15.

Ports:
- `clk_clk`  in  1  sole clock; same clock as the LVDS receiver `rx_inclock`.
- `reset_reset`  in  1  synchronous, active-high reset.
- `rx_data`  in  2  parallel bit pair; `rx_data[1]` is the earlier bit in time.
- `clear_err`  in  1  synchronous clear of `sync_err_count`.
- `word_data`  out  16  assembled data word, MSB = first received bit.
- `word_valid`  out  1  one-cycle strobe qualifying `word_data`.
- `frame_start`  out  1  high with `word_valid` for data word 0 of each frame.
- `locked`  out  1  high while in LOCKED state.
- `phase`  out  1  captured alignment: 0 = word ends on `rx_data[0]`, 1 = word ends on `rx_data[1]`.
- `sync_err_count`  out  8  saturating count of sync mismatches while locked.

## Operation
- History register `sr[17:0]`; each cycle `sr_next = {sr[15:0], rx_data[1], rx_data[0]}`. Windows: even = `sr_next[15:0]`, odd = `sr_next[16:1]`.
- States: HUNT, LOCKED. Reset enters HUNT.
- HUNT: each cycle compare both windows against `SYNC_WORD`. Even match has priority over odd when both match. On match: latch `phase`, clear bit-pair counter `pc` (3 bits) and word index `wi` (8 bits, 0 = sync slot), clear `miss_cnt`, go LOCKED. No words are output in HUNT.
- LOCKED: `pc` increments every cycle and wraps 7->0; a word completes on the cycle `pc` wraps (8 cycles per word). Completed word = window selected by `phase`.
  - `wi` = 0 (sync slot): match -> `miss_cnt` = 0; mismatch -> `miss_cnt`+1, `sync_err_count`+1 (saturates at 255). If incremented `miss_cnt` equals `MISS_LIMIT`, go HUNT. No `word_valid`.
  - `wi` = 1..`FRAME_WORDS`: output word, `word_valid`=1, `frame_start`=1 iff `wi`=1.
  - `wi` wraps `FRAME_WORDS`->0.
- Sync detection in HUNT does not require confirmation; a false match in payload is corrected by the miss mechanism.
- `clear_err` zeroes `sync_err_count`; if a mismatch increment coincides, clear wins (result 0).
- `sr` keeps shifting in both states and is not cleared by state changes.

## Timing
- Reset values: `word_data`=0, `word_valid`=0, `frame_start`=0, `locked`=0, `phase`=0, `sync_err_count`=0, `sr`=0, `miss_cnt`=0, `pc`=0, `wi`=0.
- All outputs registered. Edge E samples the last bit pair of a word -> the corresponding effect is visible from edge E (output high in the cycle after E):
  - sync found in HUNT: `locked`=1 and `phase` valid after E.
  - data word: `word_valid`/`word_data`/`frame_start` valid for exactly one cycle after E.
  - lock loss: `locked`=0 after E; HUNT comparison resumes on the next edge.
- First data word completes 8 edges after the lock edge; frame period = 8·(`FRAME_WORDS`+1) cycles.
- Reset asserted mid-frame: next edge forces all state to reset values; any in-flight word is discarded, no `word_valid`.
- `word_data` holds its last value while `word_valid`=0.

## Test plan
- Even lock: stream idle 0s, then 16'hA5C3 aligned to `rx_data[0]`, then 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0 -> `locked`=1, `phase`=0; four `word_valid` pulses 8 cycles apart with those values, `frame_start` on 16'h1234.
- Odd lock: same stream preceded by one extra 0 bit -> `phase`=1, identical words and timing shifted one bit.
- Single miss: locked, corrupt one sync (16'hA5C2) -> `sync_err_count`=1, `locked` stays 1, next frame with good sync resets `miss_cnt`, data continues.
- Lock loss: two consecutive corrupted syncs -> `locked`=0 after the second sync slot, `sync_err_count`=2, no `word_valid` until re-lock on the next good sync.
- Reset mid-frame: assert `reset_reset` one cycle during data word 2 -> all outputs 0 next cycle, no partial word, re-lock on next sync.
- Counter: 300 corrupted syncs with `MISS_LIMIT`=15 re-locking each time -> `sync_err_count` saturates at 255; `clear_err` pulse coincident with a miss -> 0.
